// File: rtl/lanzones_pkg.sv
// Shared encodings for the lanzones RV32I core: opcodes, funct3 codes, FSM states,
// ALU operations, immediate formats and the decode helpers built on them.
package lanzones_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;
  localparam logic [2:0] F3_LB   = 3'd0;
  localparam logic [2:0] F3_LH   = 3'd1;
  localparam logic [2:0] F3_LBU  = 3'd4;
  localparam logic [2:0] F3_LHU  = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM_RD, S_MEM_WR, S_HALT} state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

  function automatic logic [31:0] imm_gen(input logic [31:0] ir, input imm_sel_e sel);
    case (sel)
      IMM_S:   imm_gen = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   imm_gen = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_U:   imm_gen = {ir[31:12], 12'h000};
      IMM_J:   imm_gen = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm_gen = {{20{ir[31]}}, ir[31:20]};
    endcase
  endfunction

  // alt selects SUB/SRA; callers only raise it where the encoding allows.
  function automatic alu_op_e alu_op_dec(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_op_dec = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_op_dec = ALU_SLL;
      3'd2:    alu_op_dec = ALU_SLT;
      3'd3:    alu_op_dec = ALU_SLTU;
      3'd4:    alu_op_dec = ALU_XOR;
      3'd5:    alu_op_dec = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_op_dec = ALU_OR;
      default: alu_op_dec = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/lanzones_alu.sv
// Combinational RV32I ALU with branch-compare flags derived from the same operands.
module lanzones_alu
  import lanzones_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] result,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  always_comb begin
    eq  = (a == b);
    lt  = ($signed(a) < $signed(b));
    ltu = (a < b);
    case (alu_op_e'(op))
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'd0, lt};
      ALU_SLTU: result = {31'd0, ltu};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   result = a | b;
      default:  result = a & b;
    endcase
  end

endmodule

// File: rtl/lanzones.sv
// Multi-cycle RV32I core sharing one word-addressed memory port for fetch, load and store.
module lanzones
  import lanzones_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        LEn,
  output logic        RRdy,
  output logic [31:0] RAddr,
  input  logic        RVld,
  input  logic [31:0] RData,
  output logic        RWEn,
  output logic [31:0] RWData,
  output logic [3:0]  RWStrobe,
  output logic        Halt
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, raddr_q, raddr_d, rwdata_q, rwdata_d;
  logic [1:0]  ea_lo_q, ea_lo_d;
  logic [3:0]  strb_q, strb_d;
  logic        rrdy_q, rrdy_d, rwen_q, rwen_d, halt_q, halt_d;
  logic [31:0] rf_q [0:31];

  logic        rf_we_s;
  logic [31:0] rf_wdata_s;
  logic [6:0]  opcode_s;
  logic [2:0]  f3_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [31:0] rs1_val_s, rs2_val_s, imm_s, alu_a_s, alu_b_s, alu_res_s;
  logic [31:0] pc_plus4_s, br_tgt_s, ld_data_s;
  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;
  logic        eq_s, lt_s, ltu_s, br_take_s, rd_accept_s;
  imm_sel_e    imm_sel_s;
  alu_op_e     alu_op_s;

  assign opcode_s    = ir_q[6:0];
  assign f3_s        = ir_q[14:12];
  assign rd_s        = ir_q[11:7];
  assign rs1_s       = ir_q[19:15];
  assign rs2_s       = ir_q[24:20];
  assign rs1_val_s   = (rs1_s == 5'd0) ? 32'd0 : rf_q[rs1_s];
  assign rs2_val_s   = (rs2_s == 5'd0) ? 32'd0 : rf_q[rs2_s];
  assign imm_s       = imm_gen(ir_q, imm_sel_s);
  assign pc_plus4_s  = pc_q + 32'd4;
  assign br_tgt_s    = pc_q + imm_s;
  // RVld is only meaningful while a request is outstanding.
  assign rd_accept_s = rrdy_q & RVld;

  always_comb begin
    case (opcode_s)
      OPC_LUI, OPC_AUIPC: imm_sel_s = IMM_U;
      OPC_JAL:            imm_sel_s = IMM_J;
      OPC_BRANCH:         imm_sel_s = IMM_B;
      OPC_STORE:          imm_sel_s = IMM_S;
      default:            imm_sel_s = IMM_I;
    endcase
    alu_a_s = ((opcode_s == OPC_AUIPC) || (opcode_s == OPC_JAL)) ? pc_q : rs1_val_s;
    alu_b_s = ((opcode_s == OPC_OP) || (opcode_s == OPC_BRANCH)) ? rs2_val_s : imm_s;
    case (opcode_s)
      OPC_OP:    alu_op_s = alu_op_dec(f3_s, ir_q[30]);
      OPC_OPIMM: alu_op_s = alu_op_dec(f3_s, (f3_s == 3'd5) && ir_q[30]);
      default:   alu_op_s = ALU_ADD;
    endcase
    case (f3_s)
      F3_BEQ:  br_take_s = eq_s;
      F3_BNE:  br_take_s = !eq_s;
      F3_BLT:  br_take_s = lt_s;
      F3_BGE:  br_take_s = !lt_s;
      F3_BLTU: br_take_s = ltu_s;
      F3_BGEU: br_take_s = !ltu_s;
      default: br_take_s = 1'b0;
    endcase
  end

  lanzones_alu u_alu (
    .a      (alu_a_s),
    .b      (alu_b_s),
    .op     (alu_op_s),
    .result (alu_res_s),
    .eq     (eq_s),
    .lt     (lt_s),
    .ltu    (ltu_s)
  );

  always_comb begin
    case (ea_lo_q)
      2'd0:    ld_byte_s = RData[7:0];
      2'd1:    ld_byte_s = RData[15:8];
      2'd2:    ld_byte_s = RData[23:16];
      default: ld_byte_s = RData[31:24];
    endcase
    ld_half_s = ea_lo_q[1] ? RData[31:16] : RData[15:0];
    case (f3_s)
      F3_LB:   ld_data_s = {{24{ld_byte_s[7]}}, ld_byte_s};
      F3_LBU:  ld_data_s = {24'd0, ld_byte_s};
      F3_LH:   ld_data_s = {{16{ld_half_s[15]}}, ld_half_s};
      F3_LHU:  ld_data_s = {16'd0, ld_half_s};
      default: ld_data_s = RData;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ea_lo_d    = ea_lo_q;
    raddr_d    = raddr_q;
    rwdata_d   = rwdata_q;
    strb_d     = strb_q;
    rrdy_d     = rrdy_q;
    rwen_d     = 1'b0;
    halt_d     = halt_q;
    rf_we_s    = 1'b0;
    rf_wdata_s = alu_res_s;
    case (state_q)
      S_IDLE: begin
        if (LEn) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (rd_accept_s) begin
          ir_d    = RData;
          rrdy_d  = 1'b0;
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_plus4_s;
        case (opcode_s)
          OPC_LUI: begin
            rf_we_s    = 1'b1;
            rf_wdata_s = imm_s;
          end
          OPC_AUIPC, OPC_OP, OPC_OPIMM: rf_we_s = 1'b1;
          OPC_JAL, OPC_JALR: begin
            rf_we_s    = 1'b1;
            rf_wdata_s = pc_plus4_s;
            pc_d       = (opcode_s == OPC_JALR) ? {alu_res_s[31:1], 1'b0} : alu_res_s;
          end
          OPC_BRANCH: begin
            if (f3_s[2:1] == 2'b01) begin
              state_d = S_HALT;
            end else if (br_take_s) begin
              pc_d = br_tgt_s;
            end else begin
              pc_d = pc_plus4_s;
            end
          end
          OPC_LOAD: begin
            if (f3_s[1:0] == 2'b11 || (f3_s[2] && f3_s[1])) begin
              state_d = S_HALT;
            end else begin
              state_d = S_MEM_RD;
            end
          end
          OPC_STORE: begin
            if (f3_s[2] || f3_s[1:0] == 2'b11) begin
              state_d = S_HALT;
            end else begin
              state_d = S_MEM_WR;
            end
            rwen_d = !f3_s[2] && (f3_s[1:0] != 2'b11);
            case (f3_s[1:0])
              2'd0: begin
                rwdata_d = {4{rs2_val_s[7:0]}};
                strb_d   = 4'b0001 << alu_res_s[1:0];
              end
              2'd1: begin
                rwdata_d = {2{rs2_val_s[15:0]}};
                strb_d   = alu_res_s[1] ? 4'b1100 : 4'b0011;
              end
              default: begin
                rwdata_d = rs2_val_s;
                strb_d   = 4'b1111;
              end
            endcase
          end
          default: state_d = S_HALT;
        endcase
        if (state_d == S_MEM_RD || state_d == S_MEM_WR) begin
          pc_d    = pc_q;
          ea_lo_d = alu_res_s[1:0];
          raddr_d = {2'b00, alu_res_s[31:2]};
          rrdy_d  = (state_d == S_MEM_RD);
        end else begin
          ea_lo_d = ea_lo_q;
        end
      end
      S_MEM_RD: begin
        if (rd_accept_s) begin
          rf_we_s    = 1'b1;
          rf_wdata_s = ld_data_s;
          pc_d       = pc_plus4_s;
          state_d    = S_FETCH;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_WR: begin
        strb_d  = 4'b0000;
        pc_d    = pc_plus4_s;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // Every entry into FETCH (from any state) issues a new request at the updated PC.
    if (state_d == S_FETCH && state_q != S_FETCH) begin
      rrdy_d  = 1'b1;
      raddr_d = {2'b00, pc_d[31:2]};
    end else if (state_d == S_HALT) begin
      pc_d    = pc_q;
      rrdy_d  = 1'b0;
      rwen_d  = 1'b0;
      halt_d  = 1'b1;
    end else begin
      halt_d = halt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= 32'd0;
      ea_lo_q  <= 2'd0;
      raddr_q  <= 32'd0;
      rwdata_q <= 32'd0;
      strb_q   <= 4'd0;
      rrdy_q   <= 1'b0;
      rwen_q   <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ea_lo_q  <= ea_lo_d;
      raddr_q  <= raddr_d;
      rwdata_q <= rwdata_d;
      strb_q   <= strb_d;
      rrdy_q   <= rrdy_d;
      rwen_q   <= rwen_d;
      halt_q   <= halt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn && rf_we_s && rd_s != 5'd0) begin
      rf_q[rd_s] <= rf_wdata_s;
    end
  end

  assign RRdy     = rrdy_q;
  assign RAddr    = raddr_q;
  assign RWEn     = rwen_q;
  assign RWData   = rwdata_q;
  assign RWStrobe = strb_q;
  assign Halt     = halt_q;

endmodule

// File: tb/tb_lanzones.sv
// Directed bench for lanzones: a behavioural memory with selectable latency and
// short hand-assembled programs with hand-computed results.
module tb_lanzones;

  logic        clk = 1'b0;
  logic        rstn, LEn, RRdy, RVld, RWEn, Halt;
  logic [31:0] RAddr, RData, RWData;
  logic [3:0]  RWStrobe;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] mem [0:1023];
  int          mem_mode = 2;   // 0: zero latency, 1: registered, 2: never valid
  logic        rvld_q = 1'b0;
  logic [31:0] rdata_q = 32'd0;
  int          st_cnt, overlap_cnt, loop_cnt;
  logic [31:0] st_addr [0:7];
  logic [31:0] st_data [0:7];
  logic [3:0]  st_strb [0:7];

  lanzones dut (
    .clk(clk), .rstn(rstn), .LEn(LEn), .RRdy(RRdy), .RAddr(RAddr), .RVld(RVld),
    .RData(RData), .RWEn(RWEn), .RWData(RWData), .RWStrobe(RWStrobe), .Halt(Halt)
  );

  always #5 clk = ~clk;

  assign RVld  = (mem_mode == 0) ? 1'b1 : ((mem_mode == 1) ? rvld_q : 1'b0);
  assign RData = (mem_mode == 0) ? mem[RAddr[9:0]] : rdata_q;

  // Registered memory: answer one cycle after the request, then rest one cycle.
  always @(posedge clk) begin
    if (mem_mode == 1 && RRdy && !rvld_q) begin
      rvld_q  <= 1'b1;
      rdata_q <= mem[RAddr[9:0]];
    end else begin
      rvld_q  <= 1'b0;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_BEEF;
  endtask

  task automatic start_core();
    rstn = 1'b1;
    LEn  = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    LEn = 1'b1;
    @(negedge clk);
    LEn = 1'b0;
  endtask

  // Watches the port each cycle, applies stores to mem, stops on Halt or budget.
  task automatic run_prog(input int max_cycles, output bit halted);
    st_cnt = 0;
    overlap_cnt = 0;
    loop_cnt = 0;
    halted = 1'b0;
    for (int c = 0; c < max_cycles && !halted; c++) begin
      if (RRdy && RWEn) overlap_cnt++;
      if (RRdy && RVld && RAddr == 32'd1) loop_cnt++;
      if (RWEn) begin
        if (st_cnt < 8) begin
          st_addr[st_cnt] = RAddr;
          st_data[st_cnt] = RWData;
          st_strb[st_cnt] = RWStrobe;
        end
        for (int b = 0; b < 4; b++)
          if (RWStrobe[b]) mem[RAddr[9:0]][8*b +: 8] = RWData[8*b +: 8];
        st_cnt++;
      end
      if (Halt) halted = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    mem_mode = 2;
    rstn = 1'b1;
    LEn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (RRdy !== 1'b0) begin n_fail++; $display("FAIL reset_rrdy got=%b exp=0", RRdy); end
    n_checks++; if (RWEn !== 1'b0) begin n_fail++; $display("FAIL reset_rwen got=%b exp=0", RWEn); end
    n_checks++; if (Halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt got=%b exp=0", Halt); end
    n_checks++; if (RAddr !== 32'd0) begin n_fail++; $display("FAIL reset_raddr got=%h exp=0", RAddr); end
    n_checks++; if (RWStrobe !== 4'd0 || RWData !== 32'd0) begin
      n_fail++; $display("FAIL reset_wport got=%h/%h exp=0/0", RWStrobe, RWData);
    end
    LEn = 1'b1;
    @(negedge clk);
    LEn = 1'b0;
    n_checks++; if (RRdy !== 1'b1 || RAddr !== 32'd0) begin
      n_fail++; $display("FAIL start_fetch got rrdy=%b addr=%h exp rrdy=1 addr=0", RRdy, RAddr);
    end
  endtask

  task automatic test_store_halt(input int mode);
    bit halted;
    clear_mem();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h4010_2023;
    mem[2] = 32'h0010_0073;
    mem_mode = mode;
    start_core();
    run_prog(300, halted);
    n_checks++; if (!halted) begin n_fail++; $display("FAIL sw_halt mode=%0d got=timeout exp=halt", mode); end
    n_checks++; if (st_cnt !== 1) begin n_fail++; $display("FAIL sw_count mode=%0d got=%0d exp=1", mode, st_cnt); end
    n_checks++; if (st_addr[0] !== 32'h100) begin n_fail++; $display("FAIL sw_addr got=%h exp=100", st_addr[0]); end
    n_checks++; if (st_data[0] !== 32'd5) begin n_fail++; $display("FAIL sw_data got=%h exp=5", st_data[0]); end
    n_checks++; if (st_strb[0] !== 4'hF) begin n_fail++; $display("FAIL sw_strb got=%h exp=f", st_strb[0]); end
    n_checks++; if (mem[256] !== 32'd5) begin n_fail++; $display("FAIL sw_mem got=%h exp=5", mem[256]); end
    n_checks++; if (overlap_cnt !== 0) begin n_fail++; $display("FAIL sw_overlap got=%0d exp=0", overlap_cnt); end
    repeat (2) @(negedge clk);
    n_checks++; if (Halt !== 1'b1 || RRdy !== 1'b0 || RWEn !== 1'b0) begin
      n_fail++; $display("FAIL halt_hold got h=%b r=%b w=%b exp 1/0/0", Halt, RRdy, RWEn);
    end
  endtask

  task automatic test_byte();
    bit halted;
    clear_mem();
    mem[0] = 32'h0800_0093;
    mem[1] = 32'h4010_00A3;
    mem[2] = 32'h4010_0103;
    mem[3] = 32'h4010_4183;
    mem[4] = 32'h4020_2223;
    mem[5] = 32'h4030_2423;
    mem[6] = 32'h0010_0073;
    mem_mode = 0;
    start_core();
    run_prog(300, halted);
    n_checks++; if (!halted || st_cnt !== 3) begin
      n_fail++; $display("FAIL byte_run got halted=%b stores=%0d exp 1/3", halted, st_cnt);
    end
    n_checks++; if (st_strb[0] !== 4'b0010) begin n_fail++; $display("FAIL sb_strb got=%b exp=0010", st_strb[0]); end
    n_checks++; if (st_data[0] !== 32'h8080_8080) begin n_fail++; $display("FAIL sb_data got=%h exp=80808080", st_data[0]); end
    n_checks++; if (mem[256] !== 32'hDEAD_80EF) begin n_fail++; $display("FAIL sb_mem got=%h exp=dead80ef", mem[256]); end
    n_checks++; if (mem[257] !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_val got=%h exp=ffffff80", mem[257]); end
    n_checks++; if (mem[258] !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_val got=%h exp=00000080", mem[258]); end
  endtask

  task automatic test_branch();
    bit halted;
    clear_mem();
    mem[0] = 32'h0030_0093;
    mem[1] = 32'hFFF0_8093;
    mem[2] = 32'hFE00_9EE3;
    mem[3] = 32'h0080_02EF;
    mem[4] = 32'h4010_2623;
    mem[5] = 32'h4050_2823;
    mem[6] = 32'h4010_2A23;
    mem[7] = 32'h0000_0073;
    mem_mode = 1;
    start_core();
    run_prog(600, halted);
    n_checks++; if (!halted) begin n_fail++; $display("FAIL br_halt got=timeout exp=halt"); end
    n_checks++; if (loop_cnt !== 3) begin n_fail++; $display("FAIL br_loops got=%0d exp=3", loop_cnt); end
    n_checks++; if (st_cnt !== 2) begin n_fail++; $display("FAIL br_stores got=%0d exp=2", st_cnt); end
    n_checks++; if (mem[259] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL jal_skip got=%h exp=deadbeef", mem[259]); end
    n_checks++; if (mem[260] !== 32'h0000_0010) begin n_fail++; $display("FAIL jal_link got=%h exp=00000010", mem[260]); end
    n_checks++; if (mem[261] !== 32'd0) begin n_fail++; $display("FAIL br_x1 got=%h exp=0", mem[261]); end
    n_checks++; if (overlap_cnt !== 0) begin n_fail++; $display("FAIL br_overlap got=%0d exp=0", overlap_cnt); end
  endtask

  task automatic test_reset_mid_fetch();
    bit seen;
    clear_mem();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h4010_2023;
    mem[2] = 32'h0010_0073;
    mem_mode = 0;
    start_core();
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (RRdy && RAddr == 32'd2) seen = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_reach got=timeout exp=fetch@2"); end
    rstn = 1'b1;
    @(negedge clk);
    n_checks++; if (RRdy !== 1'b0 || Halt !== 1'b0) begin
      n_fail++; $display("FAIL mid_abort got rrdy=%b halt=%b exp 0/0", RRdy, Halt);
    end
    mem_mode = 2;
    rstn = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (RRdy !== 1'b0) begin n_fail++; $display("FAIL mid_idle got=%b exp=0", RRdy); end
    LEn = 1'b1;
    @(negedge clk);
    LEn = 1'b0;
    n_checks++; if (RRdy !== 1'b1 || RAddr !== 32'd0) begin
      n_fail++; $display("FAIL mid_refetch got rrdy=%b addr=%h exp 1/0", RRdy, RAddr);
    end
  endtask

  initial begin
    rstn = 1'b1;
    LEn  = 1'b0;
    test_reset();
    test_store_halt(0);
    test_store_halt(1);
    test_byte();
    test_branch();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lanzones.md
Name: lanzones

Overview:
- Multi-cycle, non-pipelined RV32I integer core with a single shared instruction/data memory port.
- Idle after reset until a one-cycle LEn start pulse, then fetches from PC 0.
- Executes until ECALL/EBREAK or an illegal instruction, then asserts Halt.
- Sits as the top-level CPU; an external word-addressed memory serves the port.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after LEn.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rstn  input  1  reset, synchronous and active-high (port keeps the codebase name rstn; asserted = 1).
- LEn  input  1  start pulse; sampled only in IDLE.
- RRdy  output  1  read request; held high until the accepting RVld.
- RAddr  output  32  word address = byte_addr[31:2], zero-extended.
- RVld  input  1  read data valid; a read completes on an edge where RRdy && RVld.
- RData  input  32  read word; sampled only when RRdy && RVld.
- RWEn  output  1  one-cycle write pulse.
- RWData  output  32  write data, already shifted into its byte lanes.
- RWStrobe  output  4  byte enables for the write; bit n enables RWData[8n+7:8n].
- Halt  output  1  high once halted; stays high until reset.

Behaviour:
- Reset (rstn=1 at an edge): state IDLE, PC=RESET_PC, RRdy=0, RWEn=0, RWStrobe=0, RWData=0, RAddr=0, Halt=0. Register file is not cleared; x0 always reads 0.
- FSM states: IDLE, FETCH, EXEC, MEM_RD, MEM_WR, HALT. Reset mid-operation aborts any transaction and returns to IDLE.
- IDLE: on LEn=1, go to FETCH.
- FETCH:
  - RRdy=1, RAddr=PC>>2.
  - On RRdy&&RVld: latch RData into IR, RRdy=0 next cycle, go to EXEC.
- Read handshake timing:
  - Memory may assert RVld combinationally in the same cycle as RRdy, or one or more cycles later.
  - Memory may pulse RVld for only one cycle.
  - The core must never treat RVld as valid while RRdy=0.
- EXEC (one cycle):
  - Decode and compute the ALU result.
  - Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH (BEQ, BNE, BLT, BGE, BLTU, BGEU), OP-IMM and OP (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND and their immediate forms), LOAD, STORE, SYSTEM.
  - Non-memory instructions: write rd (unless rd=0), update PC, return to FETCH.
  - PC update: PC+4, or the branch/jump target; JALR target has bit 0 cleared.
- Load (MEM_RD):
  - Effective address ea = rs1 + sext(imm); RRdy=1, RAddr=ea>>2.
  - On RRdy&&RVld: select byte/half by ea[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Write rd, PC+=4, go to FETCH.
- Store (MEM_WR, one cycle):
  - RWEn=1, RRdy=0, RAddr=ea>>2.
  - SB: strobe 4'b0001<<ea[1:0], data rs2[7:0] replicated into all lanes.
  - SH: strobe 4'b0011<<(2*ea[1]), data {2{rs2[15:0]}}.
  - SW: strobe 4'b1111.
  - Next cycle RWEn=0, PC+=4, go to FETCH.
- Misalignment: ignore low address bits not used by the access size (word aligned; half uses ea[1]); never trap.
- SYSTEM / illegal:
  - ECALL (0x00000073), EBREAK (0x00100073), or any unsupported opcode enters HALT.
  - In HALT: Halt=1, RRdy=0, RWEn=0; only reset exits.
- Arithmetic: all 32-bit modulo 2^32; shifts use the low 5 bits; SLT signed, SLTU unsigned.
- RRdy and RWEn are never high in the same cycle.

Decomposition:
- Package lanzones_pkg holds:
  - opcode constants (7-bit), funct3 codes, FSM state enum;
  - ALU operation enum;
  - immediate-type selector.
- One natural sub-module: lanzones_alu (combinational; operands a, b, op; result, plus branch-compare outputs).
- Register file and control stay in lanzones.

Test Plan:
- Reset and idle: hold rstn=1 for 3 cycles, release, LEn stays 0 for 10 cycles → RRdy=0, RWEn=0, Halt=0. Then pulse LEn → the next cycle has RRdy=1, RAddr=0.
- Store/halt, zero-latency memory (RVld tied 1):
  - Program: word0=0x00500093 (addi x1,x0,5), word1=0x40102023 (sw x1,0x400(x0)), word2=0x00100073 (ebreak).
  - Required: one RWEn pulse with RAddr=0x100, RWData=5, RWStrobe=4'hF; memory word 0x100=5; then Halt=1.
- Same program with a registered memory (RVld one cycle after RRdy, then low for one cycle) → identical final memory and Halt.
- Byte store/load:
  - Program: x1=0x80, sb x1,0x401(x0); lb x2,0x401(x0); lbu x3,0x401(x0); sw x2 and sw x3 to words 0x101 and 0x102.
  - Required: SB strobe=4'b0010; mem[0x101]=0xFFFFFF80; mem[0x102]=0x00000080.
- Branch/jump:
  - Program: loop decrementing x1 from 3 with BNE; JAL to skip one store; ECALL.
  - Required: exactly 3 loop iterations; the skipped store is never issued; the JAL link register holds its PC+4; Halt=1.
- Reset mid-fetch: assert rstn while RRdy=1 → RRdy=0 next edge; core waits for a new LEn, then fetches from RAddr=0.
